dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Data-cache controller for the MEM stage. It sits directly upstream of MEM_WB and produces the read data and the MemStall signal that the MEM_WB latch consumes.
- Cache organisation: direct-mapped, write-back, write-allocate. 2^INDEX_BITS lines of 256 bits (eight 32-bit words).
- On a miss it freezes the pipeline and runs a write-back/refill handshake with off-chip data memory.

Parameters:
- INDEX_BITS, 4, line-index width; number of lines = 2^INDEX_BITS.
- ADDR_W, 32, byte address width. Tag width = ADDR_W-INDEX_BITS-5.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- cpu_req_i  in  1  access request (MemRead|MemWrite)
- cpu_write_i  in  1  1=store, 0=load
- cpu_addr_i  in  ADDR_W  byte address; [4:2] word offset, [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data (selected word of indexed line)
- cpu_stall_o  out  1  MemStall to all pipeline latches, incl. MEM_WB
- mem_enable_o  out  1  memory request, level-held until ack
- mem_write_o  out  1  1=write-back, 0=refill read
- mem_addr_o  out  ADDR_W  line-aligned address (low 5 bits zero)
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i=0, async): state=IDLE; all valid and dirty bits cleared; mem_enable_o=0, mem_write_o=0, cpu_stall_o=0. Tag and data contents are don't-care.
- hit = valid[idx] & (tag[idx]==cpu_addr_i tag field). Combinational.
- FSM states are IDLE, WB, ALLOC and REFILL.
- IDLE:
  - No request: stall=0.
  - Request and hit: stall=0. Load data appears on cpu_data_o in the same cycle. A store writes the word at the posedge and sets dirty.
  - Request and miss: stall=1 combinationally. Next state is WB if the victim is valid and dirty, else ALLOC.
- WB: mem_enable=1, write=1, mem_addr={victim tag, idx, 5'b0}, mem_data_o=victim line, stall=1. On mem_ack_i go to ALLOC.
- ALLOC: mem_enable=1, write=0, mem_addr={req tag, idx, 5'b0}, stall=1. On mem_ack_i, at that edge:
  - line←mem_data_i
  - tag←req tag
  - valid=1, dirty=0
  - next state REFILL.
- REFILL: stall=1, mem_enable=0. Next state IDLE, where the access now hits. A store completes there and sets dirty.
- Outside WB/ALLOC: mem_enable_o=0, mem_write_o=0, mem_ack_i ignored.
- Ack in the first cycle of WB or ALLOC is legal (zero-wait memory).
- CPU holds the request stable while stall=1, because the pipeline is frozen. The controller does not latch the request.
- Miss penalty for a clean miss, with ack in the k-th ALLOC cycle: stall high for k+2 cycles. A dirty miss adds the WB cycles.
- Store miss: write-allocate. Refill first, then merge the store word in IDLE.
- Reset mid-WB/ALLOC: abandon the transaction, drop mem_enable_o immediately, invalidate all lines.
- cpu_data_o while stalled: don't-care; MEM_WB does not capture during stall.

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding (IDLE=0, WB=1, ALLOC=2, REFILL=3)
  - LINE_W=256, WORD_W=32, OFFSET_BITS=5
  - tag-width function.
- One sub-module, dcache_sram: tag, valid, dirty and data arrays.
  - Combinational read by index.
  - Synchronous write port for full-line fill and for single-word write with a dirty-set strobe.
  - Async active-low clear of valid and dirty.

Test Plan:
- Cold load 0x0000_0104, memory acks on the 3rd ALLOC cycle with line word1=0xDEADBEEF:
  - stall high 5 cycles;
  - mem_addr_o=0x100, mem_write_o=0;
  - then cpu_data_o=0xDEADBEEF with stall=0.
- Store hit to 0x108, data 0x12345678, after the line is resident: no stall. A following load of 0x108 returns 0x12345678 and dirty[idx]=1.
- Dirty eviction:
  - Setup: line idx 8 dirty with tag for 0x100, then load 0x2100 (same idx).
  - First memory transaction: WB with mem_addr_o=0x100, mem_write_o=1 and the modified line on mem_data_o.
  - Second memory transaction: ALLOC with mem_addr_o=0x2100.
- Store miss 0x300, data 0xA5A5A5A5: refill read of 0x300, then word0=0xA5A5A5A5, dirty=1. No WB if the victim is clean.
- Zero-wait memory (ack in the first ALLOC cycle): stall exactly 3 cycles.
- Assert rst_i low mid-WB:
  - mem_enable_o=0 within the same cycle, state IDLE.
  - A subsequent load of the previously resident address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the MEM-stage data cache.
//   state_t      controller FSM encoding (IDLE=0, WB=1, ALLOC=2, REFILL=3)
//   LINE_W       cache line width in bits (eight 32-bit words)
//   WORD_W       CPU word width
//   OFFSET_BITS  byte-offset bits within a line
//   tag_width()  tag width derived from address and index widths
package dcache_pkg;
  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int OFFSET_BITS    = 5;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_ALLOC  = 2'd2,
    S_REFILL = 2'd3
  } state_t;

  function automatic int tag_width(input int addr_w, input int index_bits);
    return addr_w - index_bits - OFFSET_BITS;
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side bus of the data cache.
//   cpu_*  : request/data from the MEM stage, load data and MemStall back
//   mem_*  : write-back / refill handshake with off-chip data memory
// Modports: slave = cache controller, master = CPU pipeline + memory.
interface dcache_if
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32
) ();
  logic              cpu_req_i;
  logic              cpu_write_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// dcache_sram: tag / valid / dirty / data storage of the direct-mapped cache.
//   clk_i, rst_i     clock, async active-low clear of valid and dirty bits
//   i_idx            line index for both the combinational read and the write
//   o_valid/o_dirty/o_tag/o_line   contents of the indexed line
//   i_fill_*         full-line refill: writes tag + line, valid=1, dirty=0
//   i_word_*         single-word store into the indexed line, sets dirty
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] i_idx,
  output logic                  o_valid,
  output logic                  o_dirty,
  output logic [TAG_W-1:0]      o_tag,
  output logic [LINE_W-1:0]     o_line,
  input  logic                  i_fill_en,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [LINE_W-1:0]     i_fill_line,
  input  logic                  i_word_we,
  input  logic [2:0]            i_word_sel,
  input  logic [WORD_W-1:0]     i_word_data
);
  localparam int NLINES = 1 << INDEX_BITS;

  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;
  logic [TAG_W-1:0]  r_tag [NLINES];

  // Only the status bits are reset; tags and data are meaningless while invalid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_fill_en) r_tag[i_idx] <= i_fill_tag;
  end

  // One storage array per word lane so a store touches only its own lane.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_lane
      logic [WORD_W-1:0] r_mem [NLINES];
      always_ff @(posedge clk_i) begin
        if (i_fill_en)
          r_mem[i_idx] <= i_fill_line[gi*WORD_W +: WORD_W];
        else if (i_word_we && (i_word_sel == 3'(gi)))
          r_mem[i_idx] <= i_word_data;
      end
      assign o_line[gi*WORD_W +: WORD_W] = r_mem[i_idx];
    end
  endgenerate

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for MEM.
//   clk_i  clock
//   rst_i  async active-low reset (FSM to IDLE, all lines invalidated)
//   bus    dcache_if.slave: CPU request / load data / MemStall, and the
//          level-held mem_enable_o handshake closed by a one-cycle mem_ack_i
// The CPU holds its request while stalled, so the request is never latched;
// after a refill the access is simply replayed as a hit in IDLE.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);
  localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

  state_t                r_state;
  state_t                w_state_next;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_req_tag;
  logic [TAG_W-1:0]      w_tag;
  logic [2:0]            w_word;
  logic                  w_valid;
  logic                  w_dirty;
  logic                  w_hit;
  logic [LINE_W-1:0]     w_line;
  logic                  w_fill_en;
  logic                  w_word_we;
  logic                  w_unused;

  assign w_idx     = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign w_req_tag = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_word    = bus.cpu_addr_i[OFFSET_BITS-1:2];
  assign w_unused  = ^bus.cpu_addr_i[1:0];
  assign w_hit     = w_valid && (w_tag == w_req_tag);

  dcache_sram #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_idx      (w_idx),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_tag      (w_tag),
    .o_line     (w_line),
    .i_fill_en  (w_fill_en),
    .i_fill_tag (w_req_tag),
    .i_fill_line(bus.mem_data_i),
    .i_word_we  (w_word_we),
    .i_word_sel (w_word),
    .i_word_data(bus.cpu_data_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Memory outputs decode from state alone, so an async reset drops
  // mem_enable_o in the same cycle it is asserted.
  always_comb begin
    w_state_next     = r_state;
    bus.cpu_stall_o  = 1'b0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = {w_req_tag, w_idx, OFFSET_BITS'(0)};
    w_fill_en        = 1'b0;
    w_word_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req_i) begin
          if (w_hit) begin
            w_word_we = bus.cpu_write_i;
          end else begin
            bus.cpu_stall_o = 1'b1;
            w_state_next    = (w_valid && w_dirty) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {w_tag, w_idx, OFFSET_BITS'(0)};
        if (bus.mem_ack_i) w_state_next = S_ALLOC;
      end
      S_ALLOC: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        if (bus.mem_ack_i) begin
          w_fill_en    = 1'b1;
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        // Settling cycle: the freshly filled line is read back in IDLE.
        bus.cpu_stall_o = 1'b1;
        w_state_next    = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.mem_data_o = w_line;
  assign bus.cpu_data_o = w_line[{w_word, 5'd0} +: WORD_W];
endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int INDEX_BITS = 4;
  localparam int NLINES     = 1 << INDEX_BITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(ADDR_W)) bus ();

  dcache_ctrl #(
    .INDEX_BITS(INDEX_BITS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- off-chip memory model ----------------
  logic [255:0] backing [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h104) return 32'hDEADBEEF;
    return {8'h5A, a[23:0]};
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  // ---------------- architectural view (what loads must see) ----------------
  logic [31:0] arch [int unsigned];

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (arch.exists(wa)) return arch[wa];
    l = mem_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(la + 32'(w * 4));
    return l;
  endfunction

  // Residency model: which line address each slot holds and whether it is modified.
  bit          mv_valid [NLINES];
  logic [31:0] mv_line  [NLINES];
  bit          mv_dirty [NLINES];

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0]  addr;
    bit           wr;
    logic [255:0] data;
  } txn_t;
  txn_t log_q[$];
  txn_t rsp_t;
  int   g_lat_wb    = 1;
  int   g_lat_alloc = 1;
  int   rsp_cnt     = 0;

  always @(negedge clk) begin
    bus.mem_ack_i = 1'b0;
    if (!rst_n || !bus.mem_enable_o) begin
      rsp_cnt = 0;
    end else begin
      rsp_cnt++;
      if (rsp_cnt >= (bus.mem_write_o ? g_lat_wb : g_lat_alloc)) begin
        rsp_t.addr = bus.mem_addr_o;
        rsp_t.wr   = bus.mem_write_o;
        rsp_t.data = bus.mem_data_o;
        log_q.push_back(rsp_t);
        if (bus.mem_write_o) backing[bus.mem_addr_o] = bus.mem_data_o;
        else                 bus.mem_data_i = mem_line(bus.mem_addr_o);
        bus.mem_ack_i = 1'b1;
        rsp_cnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (!bus.cpu_stall_o) chk("no_mem_req_unstalled", bus.mem_enable_o, 1'b0);
      if (bus.mem_enable_o) chk("mem_addr_aligned", bus.mem_addr_o[4:0], 5'd0);
      if (bus.cpu_req_i && !bus.cpu_write_i && !bus.cpu_stall_o)
        chk("load_data", bus.cpu_data_o, arch_word(bus.cpu_addr_i));
    end
  end

  // ---------------- one CPU access, predicted from the model ----------------
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int lat_wb, input int lat_alloc,
                        output int stalls, output logic [31:0] rdata);
    int           idx;
    logic [31:0]  la;
    bit           miss;
    bit           wb;
    int           exp_stalls;
    logic [31:0]  victim;
    logic [255:0] victim_data;
    txn_t         t;
    idx         = int'(a[8:5]);
    la          = {a[31:5], 5'b0};
    miss        = !(mv_valid[idx] && mv_line[idx] == la);
    wb          = miss && mv_valid[idx] && mv_dirty[idx];
    victim      = mv_line[idx];
    victim_data = arch_line(victim);
    exp_stalls  = !miss ? 0 : ((wb ? lat_wb : 0) + lat_alloc + 2);
    g_lat_wb    = lat_wb;
    g_lat_alloc = lat_alloc;
    log_q.delete();

    @(negedge clk);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    stalls = 0;
    #1;
    while (bus.cpu_stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = bus.cpu_data_o;
    @(posedge clk);
    #1;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;

    chk("stall_cycles", stalls, exp_stalls);
    chk("txn_count", log_q.size(), (miss ? 1 : 0) + (wb ? 1 : 0));
    if (wb && log_q.size() > 0) begin
      t = log_q[0];
      chk("wb_addr", t.addr, victim);
      chk("wb_write", t.wr, 1'b1);
      chk("wb_data", t.data, victim_data);
    end
    if (miss && log_q.size() > 0) begin
      t = log_q[log_q.size() - 1];
      chk("refill_addr", t.addr, la);
      chk("refill_write", t.wr, 1'b0);
    end
    $display("access %s addr=%08h data=%08h stalls=%0d rdata=%08h", wr ? "ST" : "LD", a, d, stalls, rdata);

    if (miss) begin
      mv_valid[idx] = 1'b1;
      mv_line[idx]  = la;
      mv_dirty[idx] = 1'b0;
    end
    if (wr) begin
      mv_dirty[idx] = 1'b1;
      arch[{a[31:2], 2'b00}] = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    int          n;
    txn_t        t;

    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_data_i  = '0;
    bus.mem_data_i  = '0;
    bus.mem_ack_i   = 1'b0;
    for (int i = 0; i < NLINES; i++) begin
      mv_valid[i] = 1'b0;
      mv_dirty[i] = 1'b0;
      mv_line[i]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", bus.cpu_stall_o, 1'b0);
    chk("rst_mem_enable", bus.mem_enable_o, 1'b0);
    chk("rst_mem_write", bus.mem_write_o, 1'b0);
    chk("rst_state", 256'(dut.r_state), 256'(S_IDLE));
    chk("rst_valid", dut.u_sram.r_valid, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold load, ack on the 3rd ALLOC cycle
    access(1'b0, 32'h104, 32'h0, 1, 3, st, rd);
    chk("cold_stalls", st, 5);
    chk("cold_rdata", rd, 32'hDEADBEEF);
    if (log_q.size() == 1) begin
      t = log_q[0];
      chk("cold_mem_addr", t.addr, 32'h100);
      chk("cold_mem_write", t.wr, 1'b0);
    end

    // Store hit, then load it back
    access(1'b1, 32'h108, 32'h12345678, 1, 1, st, rd);
    chk("sthit_stalls", st, 0);
    access(1'b0, 32'h108, 32'h0, 1, 1, st, rd);
    chk("sthit_rdata", rd, 32'h12345678);
    chk("sthit_dirty", dut.u_sram.r_dirty[8], 1'b1);

    // Dirty eviction: 0x2100 maps to the same index as 0x100
    access(1'b0, 32'h2100, 32'h0, 2, 1, st, rd);
    chk("evict_stalls", st, 5);
    if (log_q.size() == 2) begin
      t = log_q[0];
      chk("evict_wb_addr", t.addr, 32'h100);
      chk("evict_wb_write", t.wr, 1'b1);
      chk("evict_wb_word2", t.data[95:64], 32'h12345678);
      chk("evict_wb_word1", t.data[63:32], 32'hDEADBEEF);
      t = log_q[1];
      chk("evict_alloc_addr", t.addr, 32'h2100);
    end
    chk("evict_rdata", rd, 32'h5A002100);

    // Store miss over a clean victim: refill only, then merge
    access(1'b1, 32'h300, 32'hA5A5A5A5, 1, 2, st, rd);
    chk("stmiss_stalls", st, 4);
    chk("stmiss_txns", log_q.size(), 1);
    access(1'b0, 32'h300, 32'h0, 1, 1, st, rd);
    chk("stmiss_rdata", rd, 32'hA5A5A5A5);
    chk("stmiss_dirty", dut.u_sram.r_dirty[8], 1'b1);
    access(1'b0, 32'h304, 32'h0, 1, 1, st, rd);
    chk("stmiss_word1", rd, 32'h5A000304);

    // Zero-wait memory
    access(1'b0, 32'h40, 32'h0, 1, 1, st, rd);
    chk("zw_stalls", st, 3);
    chk("zw_rdata", rd, 32'h5A000040);

    // Reset in the middle of a write-back
    g_lat_wb    = 6;
    g_lat_alloc = 1;
    log_q.delete();
    @(negedge clk);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h2104;
    n = 0;
    #1;
    while (!(bus.mem_enable_o && bus.mem_write_o) && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("midwb_started", {bus.mem_enable_o, bus.mem_write_o}, 2'b11);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.cpu_req_i = 1'b0;
    #1;
    chk("midwb_enable", bus.mem_enable_o, 1'b0);
    chk("midwb_write", bus.mem_write_o, 1'b0);
    chk("midwb_stall", bus.cpu_stall_o, 1'b0);
    chk("midwb_state", 256'(dut.r_state), 256'(S_IDLE));
    chk("midwb_valid", dut.u_sram.r_valid, '0);
    $display("reset asserted during write-back at %0t", $time);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NLINES; i++) mv_valid[i] = 1'b0;
    arch.delete();
    chk("midwb_no_commit", log_q.size(), 0);

    // Previously resident lines now miss; the lost store is gone
    access(1'b0, 32'h300, 32'h0, 1, 1, st, rd);
    chk("post_rst_stalls", st, 3);
    chk("post_rst_rdata", rd, 32'h5A000300);
    access(1'b0, 32'h40, 32'h0, 1, 1, st, rd);
    chk("post_rst_miss2", st, 3);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
